apb_rmw_master: RTL and testbench

Parametrised APB master that executes queued single-beat read, write and read-add-write commands. It is the next generation of the adder-master block, generalised in address and data width. It adds a valid/ready command port, a response port, PSLVERR propagation and an optional wait-state timeout. It sits between a local controller and one APB slave segment, and drives that segment's PSEL/PENABLE handshake.

---
 rtl/apb_rmw_master.sv | 192 +++++++++++++++++++
 tb/tb_apb_rmw_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rmw_master.sv
// apb_rmw_master: queued single-beat APB read / write / read-add-write master.
// Latency: accept -> response 3 cycles (read/write), 5 cycles (read-add-write), +1 per wait state.
// Backpressure: cmd_ready_o is high only in IDLE; ACCESS stalls while pready_i is low.
//
// Ports:
//   pclk, preset                 clock (rising edge), asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o      command handshake; cmd_op_i 01 rd, 10 wr, 11 rd-add-wr, 00 no-op
//   cmd_addr_i, cmd_data_i       target address; write data or addend
//   psel_o .. pwdata_o           APB requester outputs
//   prdata_i, pready_i, pslverr_i APB completer inputs
//   rsp_valid_o/rsp_data_o/rsp_err_o  one-cycle response pulse; data forced to 0 on error
//
// Build option: define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT
// cycles with pready_i low (reported as an error response).
module apb_rmw_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   output logic              psel_o,
   output logic              penable_o,
   output logic [ADDR_W-1:0] paddr_o,
   output logic              pwrite_o,
   output logic [DATA_W-1:0] pwdata_o,
   input  logic [DATA_W-1:0] prdata_i,
   input  logic              pready_i,
   input  logic              pslverr_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

   localparam logic [1:0] OP_RD  = 2'b01;
   localparam logic [1:0] OP_WR  = 2'b10;
   localparam logic [1:0] OP_RMW = 2'b11;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("apb_rmw_master: TIMEOUT must be at least 1");
   end

   state_t            state_q, state_d;
   logic              phase_q, phase_d;      // 0: read half, 1: write half of op 11
   logic [1:0]        op_q, op_d;
   logic [DATA_W-1:0] addend_q, addend_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic              timed_out;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] wait_cnt_q;

   // Counts ACCESS cycles already spent; equals TIMEOUT-1 in the TIMEOUT-th one.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset)
         wait_cnt_q <= '0;
      else if (state_q != S_ACCESS)
         wait_cnt_q <= '0;
      else
         wait_cnt_q <= wait_cnt_q + 1'b1;
   end

   assign timed_out = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q     <= S_IDLE;
         phase_q     <= 1'b0;
         op_q        <= '0;
         addend_q    <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         op_q        <= op_d;
         addend_q    <= addend_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      op_d        = op_q;
      addend_d    = addend_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               op_d     = cmd_op_i;
               addend_d = cmd_data_i;
               // A no-op is consumed here without touching the bus.
               if (cmd_op_i != 2'b00) begin
                  state_d   = S_SETUP;
                  phase_d   = 1'b0;
                  psel_d    = 1'b1;
                  penable_d = 1'b0;
                  paddr_d   = cmd_addr_i;
                  pwrite_d  = (cmd_op_i == OP_WR);
                  if (cmd_op_i == OP_WR)
                     pwdata_d = cmd_data_i;
               end
            end
         end

         S_SETUP: begin
            state_d   = S_ACCESS;
            penable_d = 1'b1;
         end

         S_ACCESS: begin
            if (pready_i) begin
               if (op_q == OP_RMW && !phase_q && !pslverr_i) begin
                  // Chain the write half straight into a new SETUP.
                  state_d   = S_SETUP;
                  phase_d   = 1'b1;
                  penable_d = 1'b0;
                  pwrite_d  = 1'b1;
                  pwdata_d  = prdata_i + addend_q;
               end else begin
                  state_d     = S_IDLE;
                  psel_d      = 1'b0;
                  penable_d   = 1'b0;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = pslverr_i;
                  rsp_data_d  = pslverr_i ? '0 : (pwrite_q ? pwdata_q : prdata_i);
               end
            end else if (timed_out) begin
               state_d     = S_IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_data_d  = '0;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign cmd_ready_o = (state_q == S_IDLE) && !preset;
   assign psel_o      = psel_q;
   assign penable_o   = penable_q;
   assign paddr_o     = paddr_q;
   assign pwrite_o    = pwrite_q;
   assign pwdata_o    = pwdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_rmw_master.sv
// tb_apb_rmw_master: randomized bench for apb_rmw_master with a memory-backed APB completer.
// Latency: n/a (bench).
// Backpressure: completer inserts planned wait states and errors per transfer half.
module tb_apb_rmw_master;

   localparam int TO = 4;

   logic        pclk = 1'b0;
   logic        preset;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [1:0]  cmd_op_i;
   logic [31:0] cmd_addr_i;
   logic [31:0] cmd_data_i;
   logic        psel_o;
   logic        penable_o;
   logic [31:0] paddr_o;
   logic        pwrite_o;
   logic [31:0] pwdata_o;
   logic [31:0] prdata_i;
   logic        pready_i;
   logic        pslverr_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_data_o;
   logic        rsp_err_o;

   apb_rmw_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
      .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
      .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
      .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
      .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
   );

   always #5 pclk = ~pclk;

   // One planned APB transfer (a command half) as the completer should see it.
   typedef struct {
      logic [31:0] addr;
      bit          wr;
      logic [31:0] wdata;
      int          waits;
      bit          err;
   } half_t;

   half_t       halves[$];
   half_t       cur;
   logic [31:0] ref_mem [256];
   logic [31:0] slv_mem [256];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          acc_cnt = 0;
   int          psel_cnt = 0;
   int          pen_cnt  = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit times_out(input int w);
`ifdef APB_TIMEOUT_EN
      return (w >= TO);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int acc_cycles(input int w);
      return times_out(w) ? TO : w + 1;
   endfunction

   task automatic set_mem(input logic [7:0] idx, input logic [31:0] val);
      ref_mem[idx] = val;
      slv_mem[idx] = val;
   endtask

   // APB completer: serves transfers from the plan queue, sampled on the falling edge.
   always @(negedge pclk) begin
      if (psel_o) psel_cnt++;
      if (penable_o) pen_cnt++;
      if (psel_o && penable_o) begin
         if (acc_cnt == 0) begin
            if (halves.size() == 0) begin
               check_val("unexpected_access", 1, 0);
               cur = '{addr: paddr_o, wr: pwrite_o, wdata: pwdata_o, waits: 0, err: 1'b0};
            end else begin
               cur = halves.pop_front();
            end
            check_val("paddr", paddr_o, cur.addr);
            check_val("pwrite", pwrite_o, cur.wr);
            if (cur.wr) check_val("pwdata", pwdata_o, cur.wdata);
         end
         if (acc_cnt == cur.waits) begin
            pready_i  = 1'b1;
            pslverr_i = cur.err;
            prdata_i  = cur.wr ? $urandom : slv_mem[cur.addr[7:0]];
            if (cur.wr && !cur.err) slv_mem[cur.addr[7:0]] = pwdata_o;
            acc_cnt = 0;
         end else begin
            pready_i  = 1'b0;
            pslverr_i = 1'($urandom_range(0, 1));
            prdata_i  = $urandom;
            acc_cnt++;
         end
      end else begin
         acc_cnt   = 0;
         pready_i  = 1'($urandom_range(0, 1));
         pslverr_i = 1'($urandom_range(0, 1));
         prdata_i  = $urandom;
      end
   end

   // Issue one command from a falling edge, predict its outcome, and check the response.
   task automatic do_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input int w0, input bit e0, input int w1, input bit e1, input int gap);
      half_t       h;
      int          nh = 0;
      int          pen_exp = 0;
      bit          exp_err = 1'b0;
      logic [31:0] exp_data = '0;
      logic [31:0] sum;
      int          ps0, pe0, cyc;
      bit          got;

      if (op != 2'b00) begin
         h = '{addr: addr, wr: (op == 2'b10), wdata: data, waits: w0, err: e0};
         halves.push_back(h);
         nh++;
         pen_exp += acc_cycles(w0);
         if (times_out(w0) || e0) begin
            exp_err = 1'b1;
         end else if (op == 2'b01) begin
            exp_data = ref_mem[addr[7:0]];
         end else if (op == 2'b10) begin
            ref_mem[addr[7:0]] = data;
            exp_data = data;
         end else begin
            sum = ref_mem[addr[7:0]] + data;
            h = '{addr: addr, wr: 1'b1, wdata: sum, waits: w1, err: e1};
            halves.push_back(h);
            nh++;
            pen_exp += acc_cycles(w1);
            if (times_out(w1) || e1) begin
               exp_err = 1'b1;
            end else begin
               ref_mem[addr[7:0]] = sum;
               exp_data = sum;
            end
         end
      end

      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_addr_i  = addr;
      cmd_data_i  = data;
      check_val("cmd_ready", cmd_ready_o, 1);
      @(posedge pclk);
      ps0 = psel_cnt;
      pe0 = pen_cnt;
      #1;
      cmd_valid_i = 1'b0;
      cmd_op_i    = 2'($urandom);
      cmd_addr_i  = $urandom;
      cmd_data_i  = $urandom;

      if (op == 2'b00) begin
         repeat (3) begin
            @(negedge pclk);
            check_val("nop_psel", psel_o, 0);
            check_val("nop_rsp", rsp_valid_o, 0);
         end
      end else begin
         cyc = 0;
         got = 1'b0;
         while (!got && cyc < 400) begin
            @(negedge pclk);
            cyc++;
            got = rsp_valid_o;
         end
         check_val("rsp_seen", got, 1);
         if (got) begin
            check_val("latency", cyc, 1 + nh + pen_exp);
            check_val("rsp_err", rsp_err_o, exp_err);
            check_val("rsp_data", rsp_data_o, exp_data);
            check_val("psel_cycles", psel_cnt - ps0, nh + pen_exp);
            check_val("penable_cycles", pen_cnt - pe0, pen_exp);
         end
      end

      repeat (gap) begin
         @(negedge pclk);
         check_val("rsp_single_pulse", rsp_valid_o, 0);
      end
   endtask

   initial begin
      half_t       h;
      logic [1:0]  op;
      int          w0, w1;

      preset      = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_op_i    = 2'b00;
      cmd_addr_i  = '0;
      cmd_data_i  = '0;
      pready_i    = 1'b0;
      pslverr_i   = 1'b0;
      prdata_i    = '0;
      for (int i = 0; i < 256; i++) set_mem(8'(i), $urandom);
      #1 preset = 1'b1;

      @(negedge pclk);
      check_val("rst_cmd_ready", cmd_ready_o, 0);
      check_val("rst_psel", psel_o, 0);
      check_val("rst_penable", penable_o, 0);
      check_val("rst_paddr", paddr_o, 0);
      check_val("rst_pwrite", pwrite_o, 0);
      check_val("rst_pwdata", pwdata_o, 0);
      check_val("rst_rsp_valid", rsp_valid_o, 0);
      check_val("rst_rsp_data", rsp_data_o, 0);
      check_val("rst_rsp_err", rsp_err_o, 0);
      preset = 1'b0;
      @(negedge pclk);

      // Directed cases.
      set_mem(8'h10, 32'h5);
      do_cmd(2'b01, 32'h10, 32'h0, 1, 1'b0, 0, 1'b0, 1);         // read, one wait
      set_mem(8'h20, 32'h7);
      do_cmd(2'b11, 32'h20, 32'h3, 0, 1'b0, 0, 1'b0, 0);         // read-add-write
      set_mem(8'h24, 32'hFFFF_FFFF);
      do_cmd(2'b11, 32'h24, 32'h1, 0, 1'b0, 0, 1'b0, 1);         // wrap-around
      do_cmd(2'b11, 32'h28, 32'h5, 0, 1'b1, 0, 1'b0, 0);         // error on read half
      do_cmd(2'b10, 32'h2C, 32'h1234, 0, 1'b0, 0, 1'b0, 0);      // write, back-to-back
      do_cmd(2'b01, 32'h2C, 32'h0, 0, 1'b0, 0, 1'b0, 0);         // read it back
      do_cmd(2'b01, 32'h14, 32'h0, 20, 1'b0, 0, 1'b0, 1);        // long wait / timeout
      do_cmd(2'b11, 32'h18, 32'h9, 0, 1'b0, TO - 1, 1'b0, 0);    // ready in last allowed cycle
      do_cmd(2'b00, 32'h10, 32'h0, 0, 1'b0, 0, 1'b0, 0);         // no-op

      // Reset in the second ACCESS cycle of a read.
      h = '{addr: 32'h30, wr: 1'b0, wdata: '0, waits: 10, err: 1'b0};
      halves.push_back(h);
      cmd_valid_i = 1'b1;
      cmd_op_i    = 2'b01;
      cmd_addr_i  = 32'h30;
      @(posedge pclk);
      #1 cmd_valid_i = 1'b0;
      repeat (3) @(negedge pclk);
      check_val("pre_reset_penable", penable_o, 1);
      #2 preset = 1'b1;
      #1;
      check_val("mid_reset_psel", psel_o, 0);
      check_val("mid_reset_penable", penable_o, 0);
      check_val("mid_reset_ready", cmd_ready_o, 0);
      @(negedge pclk);
      check_val("mid_reset_rsp", rsp_valid_o, 0);
      preset = 1'b0;
      @(negedge pclk);
      check_val("post_reset_rsp", rsp_valid_o, 0);
      check_val("post_reset_ready", cmd_ready_o, 1);
      do_cmd(2'b01, 32'h30, 32'h0, 0, 1'b0, 0, 1'b0, 0);

      // Randomized traffic.
      for (int n = 0; n < 80; n++) begin
         op = 2'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 3));
         w0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 1);
         w1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 1);
         do_cmd(op, {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom,
                w0, ($urandom_range(0, 7) == 0), w1, ($urandom_range(0, 7) == 0),
                $urandom_range(0, 2));
      end

      check_val("plan_drained", halves.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
